// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: emits round keys 0..10 one per request, using a single
// shared S-box stepped over the four bytes of RotWord(w3).
module aes_key_schedule #(
    parameter int NROUNDS    = 10,
    parameter int SUB_CYCLES = 4
) (
    input  logic         int_osc,
    input  logic         load,
    input  logic [127:0] key,
    input  logic         add,
    output logic [127:0] nextkey,
    output logic         complete,
    output logic [3:0]   round
);

    localparam logic [1:0] LOAD0  = 2'd0;
    localparam logic [1:0] READY  = 2'd1;
    localparam logic [1:0] SUB    = 2'd2;
    localparam logic [1:0] EXPAND = 2'd3;

    localparam logic [1:0] LAST_IDX = 2'(SUB_CYCLES - 1);
    localparam logic [3:0] MAX_RND  = 4'(NROUNDS);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constant for the key that is about to be produced (current round + 1).
    function automatic logic [7:0] rcon_next(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic         complete_q, complete_d;
    logic [3:0]   round_q, round_d;
    logic [31:0]  tmp_q, tmp_d;
    logic [1:0]   idx_q, idx_d;
    logic         add_q;

    logic [31:0]  rot_w;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;
    logic [31:0]  t_w, w4, w5, w6, w7;

    assign rot_w    = {key_q[23:0], key_q[31:24]};
    assign sbox_out = SBOX[sbox_in];

    always_comb begin
        sbox_in = 8'h00;
        case (idx_q)
            2'd0:    sbox_in = rot_w[31:24];
            2'd1:    sbox_in = rot_w[23:16];
            2'd2:    sbox_in = rot_w[15:8];
            default: sbox_in = rot_w[7:0];
        endcase
    end

    assign t_w = tmp_q ^ {rcon_next(round_q), 24'h000000};
    assign w4  = key_q[127:96] ^ t_w;
    assign w5  = key_q[95:64]  ^ w4;
    assign w6  = key_q[63:32]  ^ w5;
    assign w7  = key_q[31:0]   ^ w6;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        complete_d = complete_q;
        round_d    = round_q;
        tmp_d      = tmp_q;
        idx_d      = idx_q;
        case (state_q)
            LOAD0: begin
                key_d      = key;
                round_d    = 4'd0;
                complete_d = 1'b0;
                state_d    = READY;
            end
            READY: begin
                complete_d = 1'b1;
                if (add && !add_q && (round_q < MAX_RND)) begin
                    state_d    = SUB;
                    idx_d      = 2'd0;
                    complete_d = 1'b0;
                end
            end
            SUB: begin
                complete_d = 1'b0;
                case (idx_q)
                    2'd0:    tmp_d[31:24] = sbox_out;
                    2'd1:    tmp_d[23:16] = sbox_out;
                    2'd2:    tmp_d[15:8]  = sbox_out;
                    default: tmp_d[7:0]   = sbox_out;
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = EXPAND;
                end
            end
            default: begin
                key_d      = {w4, w5, w6, w7};
                round_d    = round_q + 4'd1;
                complete_d = 1'b1;
                state_d    = READY;
            end
        endcase
    end

    // add_q resets high so a request line already held high is not taken as an edge.
    always_ff @(posedge int_osc) begin
        if (load) begin
            state_q    <= LOAD0;
            key_q      <= '0;
            complete_q <= 1'b0;
            round_q    <= 4'd0;
            tmp_q      <= '0;
            idx_q      <= 2'd0;
            add_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            complete_q <= complete_d;
            round_q    <= round_d;
            tmp_q      <= tmp_d;
            idx_q      <= idx_d;
            add_q      <= add;
        end
    end

    assign nextkey  = key_q;
    assign complete = complete_q;
    assign round    = round_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboarded bench for aes_key_schedule: a GF(2^8)-derived reference key
// expansion feeds an expectation queue drained whenever complete rises.
module tb_aes_key_schedule;

    logic         int_osc = 1'b0;
    logic         load;
    logic [127:0] key;
    logic         add;
    logic [127:0] nextkey;
    logic         complete;
    logic [3:0]   round;

    always #5 int_osc = ~int_osc;

    aes_key_schedule #(.NROUNDS(10), .SUB_CYCLES(4)) dut (
        .int_osc (int_osc),
        .load    (load),
        .key     (key),
        .add     (add),
        .nextkey (nextkey),
        .complete(complete),
        .round   (round)
    );

    typedef struct {
        logic [3:0]   r;
        logic [127:0] k;
    } exp_t;

    int           total = 0;
    int           bad   = 0;
    int           cur_round;
    logic [7:0]   sb [256];
    logic [127:0] rk [11];
    exp_t         expq [$];
    bit           prev_complete = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from multiplicative inverse plus affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_exp(input int r);
        exp_t e;
        e.r = 4'(r);
        e.k = rk[r];
        expq.push_back(e);
    endtask

    // Monitor: every rising complete must match the oldest expected key.
    initial begin
        forever begin
            @(negedge int_osc);
            if (complete === 1'b1 && !prev_complete) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got round %0d key %h, expected no new key", round, nextkey);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("mon_round", 128'(round), 128'(e.r));
                    chk("mon_key", nextkey, e.k);
                end
            end
            prev_complete = (complete === 1'b1);
        end
    end

    task automatic wait_ready();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge int_osc);
            if (complete === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL wait_ready: got complete=%b, required 1 within 20 cycles", complete);
        end
    endtask

    task automatic do_load(input logic [127:0] k, input logic addv);
        load = 1'b1;
        key  = k;
        add  = addv;
        for (int i = 0; i < 2; i++) begin
            @(posedge int_osc);
            @(negedge int_osc);
            chk("rst_nextkey", nextkey, 128'h0);
            chk("rst_complete", 128'(complete), 128'h0);
            chk("rst_round", 128'(round), 128'h0);
        end
        expand_model(k);
        cur_round = 0;
        push_exp(0);
        load = 1'b0;
        @(posedge int_osc);
        @(negedge int_osc);
        chk("load_nextkey", nextkey, k);
        chk("load_round", 128'(round), 128'h0);
        chk("load_complete_low", 128'(complete), 128'h0);
        @(posedge int_osc);
        @(negedge int_osc);
        chk("load_complete_high", 128'(complete), 128'h1);
    endtask

    // One request; spur in 1..5 injects an extra one-cycle add pulse while busy.
    task automatic req(input int spur, input bit hold);
        wait_ready();
        add = 1'b0;
        @(posedge int_osc);
        #1;
        cur_round++;
        push_exp(cur_round);
        add = 1'b1;
        @(posedge int_osc);
        #1;
        if (!hold) add = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == spur) add = 1'b1;
            @(negedge int_osc);
            chk("busy_complete", 128'(complete), 128'h0);
            @(posedge int_osc);
            #1;
            if (!hold) add = 1'b0;
        end
        @(negedge int_osc);
        chk("done_complete", 128'(complete), 128'h1);
        chk("done_round", 128'(round), 128'(cur_round));
        chk("done_key", nextkey, rk[cur_round]);
        if (hold) begin
            repeat (15) @(posedge int_osc);
            #1;
            chk("hold_round", 128'(round), 128'(cur_round));
            chk("hold_key", nextkey, rk[cur_round]);
            add = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion within 50000 cycles");
        $fatal(1);
    end

    initial begin
        logic [127:0] rkey;
        load = 1'b1;
        add  = 1'b0;
        key  = '0;
        build_sbox();

        // Reset with add held high: no expansion may start.
        do_load(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        repeat (8) @(posedge int_osc);
        #1;
        chk("held_add_round", 128'(round), 128'h0);
        chk("held_add_complete", 128'(complete), 128'h1);
        add = 1'b0;

        req(0, 1'b0);
        chk("r1_const", nextkey, 128'ha0fafe1788542cb123a339392a6c7605);
        req(0, 1'b1);
        chk("r2_const", nextkey, 128'hf2c295f27a96b9435935807a7359f67f);
        req(3, 1'b0);
        for (int r = 4; r <= 10; r++) begin
            repeat ($urandom_range(0, 3)) @(posedge int_osc);
            req($urandom_range(0, 5), 1'b0);
        end
        chk("r10_const", nextkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Edge at round 10 must be ignored.
        add = 1'b0;
        @(posedge int_osc);
        #1;
        add = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge int_osc);
            chk("sat_complete", 128'(complete), 128'h1);
            chk("sat_round", 128'(round), 128'd10);
            chk("sat_key", nextkey, rk[10]);
            @(posedge int_osc);
            #1;
            add = 1'b0;
        end

        // Abort an expansion with a reload partway through SubWord.
        do_load(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        @(posedge int_osc);
        #1;
        add = 1'b1;
        @(posedge int_osc);
        #1;
        add = 1'b0;
        repeat (2) begin
            @(posedge int_osc);
            #1;
        end
        do_load(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        req(0, 1'b0);
        chk("abort_r1_const", nextkey, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

        // Random keys with random gaps and dropped busy-time edges.
        for (int n = 0; n < 3; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            do_load(rkey, 1'($urandom_range(0, 1)));
            for (int r = 1; r <= 10; r++) begin
                repeat ($urandom_range(0, 3)) @(posedge int_osc);
                req($urandom_range(0, 5), (n == 0 && r == 5));
            end
        end

        repeat (4) @(posedge int_osc);
        @(negedge int_osc);
        chk("queue_empty", 128'(expq.size()), 128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
